// File: rtl/fp_mc_wb_arbiter.sv
// ---------------------------------------------------------------------------
// fp_mc_wb_arbiter
//
// Writeback arbiter for the multicycle FP units (sqrt, fdiv, ...). Each unit
// raises a one-cycle completion pulse with its result and pipeline bus. The
// pulse is captured into a per-source holding slot. Each enabled cycle one
// valid slot is picked round-robin and written out through a single
// registered writeback port. A unit whose slot is full and not being drained
// this cycle sees its enable low, freezes, and re-presents its result later.
//
// Ports
//   clk          core clock
//   rst          synchronous active-high reset
//   clear        synchronous pipeline flush (empties slots, kills p_out)
//   en           downstream pipeline enable, 0 = stall
//   src_p_i      per-unit result-valid pulse
//   src_result_i per-unit result, source i at [i*DATA_W +: DATA_W]
//   src_bus_i    per-unit bus, source i at [i*BUS_W +: BUS_W]
//   src_en_o     per-unit enable (combinational from en, slots, rr pointer)
//   pending_o    slot i occupied
//   p_out        writeback valid (registered)
//   result_out   writeback result (registered)
//   bus_o        writeback bus (registered)
//   src_id_o     index of the winning source (registered)
// ---------------------------------------------------------------------------
module fp_mc_wb_arbiter #(
    parameter int N_SRC  = 2,
    parameter int DATA_W = 32,
    parameter int BUS_W  = 152
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       en,
    input  logic [N_SRC-1:0]           src_p_i,
    input  logic [N_SRC*DATA_W-1:0]    src_result_i,
    input  logic [N_SRC*BUS_W-1:0]     src_bus_i,
    output logic [N_SRC-1:0]           src_en_o,
    output logic [N_SRC-1:0]           pending_o,
    output logic                       p_out,
    output logic [DATA_W-1:0]          result_out,
    output logic [BUS_W-1:0]           bus_o,
    output logic [$clog2(N_SRC)-1:0]   src_id_o
);

    localparam int ID_W  = $clog2(N_SRC);
    localparam int SUM_W = ID_W + 1;
    localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(N_SRC - 1);
    localparam logic [SUM_W-1:0] N_WIDE   = SUM_W'(N_SRC);

    logic [N_SRC-1:0]  slot_v_q, slot_v_d;
    logic [DATA_W-1:0] slot_res_q [N_SRC];
    logic [DATA_W-1:0] slot_res_d [N_SRC];
    logic [BUS_W-1:0]  slot_bus_q [N_SRC];
    logic [BUS_W-1:0]  slot_bus_d [N_SRC];
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic              p_q, p_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [BUS_W-1:0]  bus_q, bus_d;
    logic [ID_W-1:0]   id_q, id_d;

    logic [N_SRC-1:0]  grant;
    logic [N_SRC-1:0]  cap;
    logic              grant_any;
    logic [ID_W-1:0]   grant_idx;
    logic [SUM_W-1:0]  scan_idx;

    // Round-robin scan starting at rr_ptr, wrapping modulo N_SRC. Built from
    // registered state only so a unit's p_out can never loop back into its en.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (scan_idx >= N_WIDE) begin
                scan_idx = scan_idx - N_WIDE;
            end
            if (!grant_any && slot_v_q[scan_idx[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx[ID_W-1:0];
            end
        end
        grant[grant_idx] = grant_any;
    end

    // A unit may present only if its slot is empty or being drained this cycle.
    assign src_en_o = {N_SRC{en}} & (~slot_v_q | grant);
    assign cap      = src_p_i & src_en_o;

    always_comb begin
        slot_v_d   = slot_v_q;
        slot_res_d = slot_res_q;
        slot_bus_d = slot_bus_q;
        rr_ptr_d   = rr_ptr_q;
        p_d        = p_q;
        res_d      = res_q;
        bus_d      = bus_q;
        id_d       = id_q;

        if (clear) begin
            // Captures in the flush cycle are dropped; rr pointer keeps its place.
            slot_v_d = '0;
            p_d      = 1'b0;
        end else if (en) begin
            p_d = grant_any;
            if (grant_any) begin
                res_d    = slot_res_q[grant_idx];
                bus_d    = slot_bus_q[grant_idx];
                id_d     = grant_idx;
                rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + ID_W'(1);
            end
            for (int i = 0; i < N_SRC; i++) begin
                // A capture on the granted slot refills it (back-to-back).
                if (cap[i]) begin
                    slot_v_d[i]   = 1'b1;
                    slot_res_d[i] = src_result_i[i*DATA_W +: DATA_W];
                    slot_bus_d[i] = src_bus_i[i*BUS_W +: BUS_W];
                end else if (grant[i]) begin
                    slot_v_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_v_q <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                slot_res_q[i] <= '0;
                slot_bus_q[i] <= '0;
            end
            rr_ptr_q <= '0;
            p_q      <= 1'b0;
            res_q    <= '0;
            bus_q    <= '0;
            id_q     <= '0;
        end else begin
            slot_v_q   <= slot_v_d;
            slot_res_q <= slot_res_d;
            slot_bus_q <= slot_bus_d;
            rr_ptr_q   <= rr_ptr_d;
            p_q        <= p_d;
            res_q      <= res_d;
            bus_q      <= bus_d;
            id_q       <= id_d;
        end
    end

    assign pending_o  = slot_v_q;
    assign p_out      = p_q;
    assign result_out = res_q;
    assign bus_o      = bus_q;
    assign src_id_o   = id_q;

endmodule
